// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between four requesters, the arbiter and the downstream consumer.
// master: requester/consumer side; slave: the arbiter.
interface rr_mux_arbiter_if #(
  parameter int unsigned N = 4
) ();
  logic [3:0]   req;
  logic [N-1:0] InA;
  logic [N-1:0] InB;
  logic [N-1:0] InC;
  logic [N-1:0] InD;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] Out;
  logic [1:0]   S;
  logic [3:0]   grant;
  logic [3:0]   ack;

  modport master (
    output req, InA, InB, InC, InD, out_ready,
    input  out_valid, Out, S, grant, ack
  );

  modport slave (
    input  req, InA, InB, InC, InD, out_ready,
    output out_valid, Out, S, grant, ack
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Four-way arbiter with a registered N-bit output stage and back-to-back re-arbitration.
// Define RR_MUX_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority A>B>C>D.
module rr_mux_arbiter #(
  parameter int unsigned N = 4
) (
  input logic             clk,
  input logic             rst,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e       state_q;
  logic [N-1:0] out_q;
  logic [1:0]   s_q;
  logic [3:0]   grant_q;

  logic         xfer;
  logic [3:0]   cand;
  logic [1:0]   win_idx;
  logic         win_any;
  logic [N-1:0] mux_out;

  assign xfer = (state_q == StBusy) && bus.out_ready;
  // The outgoing winner is masked so it cannot win again on its own transfer edge.
  assign cand = (state_q == StBusy) ? (bus.req & ~grant_q) : bus.req;

`ifdef RR_MUX_ARBITER_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  logic [1:0] start;
  logic [1:0] rr_idx;

  // On a transfer edge the search already starts from the pointer value being written.
  assign start = xfer ? (s_q + 2'd1) : ptr_q;

  always_comb begin
    win_any = 1'b0;
    win_idx = 2'd0;
    rr_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      rr_idx = start + 2'(k);
      if (!win_any && cand[rr_idx]) begin
        win_any = 1'b1;
        win_idx = rr_idx;
      end
    end
  end
`else
  always_comb begin
    win_any = |cand;
    win_idx = 2'd0;
    if (cand[0])      win_idx = 2'd0;
    else if (cand[1]) win_idx = 2'd1;
    else if (cand[2]) win_idx = 2'd2;
    else if (cand[3]) win_idx = 2'd3;
  end
`endif

  // Quad N-bit 4:1 data mux, steered by the next-winner index.
  always_comb begin
    mux_out = bus.InA;
    unique case (win_idx)
      2'd0: mux_out = bus.InA;
      2'd1: mux_out = bus.InB;
      2'd2: mux_out = bus.InC;
      2'd3: mux_out = bus.InD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      s_q     <= 2'd0;
      grant_q <= 4'b0000;
`ifdef RR_MUX_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_any) begin
            state_q <= StBusy;
            grant_q <= 4'b0001 << win_idx;
            s_q     <= win_idx;
            out_q   <= mux_out;
          end
        end
        StBusy: begin
          if (xfer) begin
`ifdef RR_MUX_ARBITER_ROUND_ROBIN_EN
            ptr_q <= s_q + 2'd1;
`endif
            if (win_any) begin
              grant_q <= 4'b0001 << win_idx;
              s_q     <= win_idx;
              out_q   <= mux_out;
            end else begin
              state_q <= StIdle;
              grant_q <= 4'b0000;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = (state_q == StBusy);
  assign bus.Out       = out_q;
  assign bus.S         = s_q;
  assign bus.grant     = grant_q;
  assign bus.ack       = (xfer && !rst) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a queue-based arbitration model predicts each granted
// word; a negedge monitor compares the DUT's output stage against the queue.
module tb_rr_mux_arbiter;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_mux_arbiter_if #(.N(N)) bus ();

  rr_mux_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [N-1:0] data;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] din[4];
  bit           m_busy = 1'b0;
  bit           cur_busy = 1'b0;
  int           m_win = 0;
  int           m_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit rr_en();
`ifdef RR_MUX_ARBITER_ROUND_ROBIN_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs after the edge, then predict what the next edge does.
  task automatic apply(input logic [3:0] r, input bit rdy);
    logic [3:0] cand;
    int         found;
    @(posedge clk);
    #2;
    cur_busy      = m_busy;
    bus.req       = r;
    bus.InA       = din[0];
    bus.InB       = din[1];
    bus.InC       = din[2];
    bus.InD       = din[3];
    bus.out_ready = rdy;
    if (m_busy && !rdy) return;
    cand = r;
    if (m_busy) begin
      cand[m_win] = 1'b0;
      m_ptr       = (m_win + 1) % 4;
    end
    found = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = rr_en() ? (m_ptr + k) % 4 : k;
      if (found < 0 && cand[i]) found = i;
    end
    if (found >= 0) begin
      m_busy = 1'b1;
      m_win  = found;
      sb.push_back('{idx: found, data: din[found]});
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst           = 1'b1;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_Out", bus.Out, 0);
    chk("rst_S", bus.S, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_ack", bus.ack, 0);
    sb.delete();
    m_busy   = 1'b0;
    cur_busy = 1'b0;
    m_ptr    = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      chk("rst_hold_ack", bus.ack, 0);
      chk("rst_hold_grant", bus.grant, 0);
    end else begin
      chk("out_valid", bus.out_valid, cur_busy);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: out_valid=1 with no expected word queued");
        end else begin
          e = sb[0];
          chk("S", bus.S, e.idx);
          chk("Out", bus.Out, e.data);
          chk("grant", bus.grant, 4'b0001 << e.idx);
          chk("ack", bus.ack, bus.out_ready ? (4'b0001 << e.idx) : 4'b0000);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_grant", bus.grant, 0);
        chk("idle_ack", bus.ack, 0);
      end
    end
  end

  initial begin
    logic [3:0] r;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    bus.InA       = '0;
    bus.InB       = '0;
    bus.InC       = '0;
    bus.InD       = '0;
    for (int b = 0; b < 4; b++) din[b] = '0;

    do_reset();

    // Single request from A, then back to idle.
    din[0] = 4'h5;
    apply(4'b0001, 1'b1);
    apply(4'b0000, 1'b1);
    apply(4'b0000, 1'b1);

    // All four requesting with the consumer always ready.
    din[0] = 4'h1;
    din[1] = 4'h2;
    din[2] = 4'h3;
    din[3] = 4'h4;
    repeat (6) apply(4'b1111, 1'b1);
    repeat (2) apply(4'b0000, 1'b1);

    // Stall on B while its data and the request vector change.
    din[1] = 4'hA;
    apply(4'b0010, 1'b0);
    din[1] = 4'h3;
    repeat (3) apply(4'b1100, 1'b0);
    apply(4'b1100, 1'b1);
    repeat (4) apply(4'b0000, 1'b1);

    // Pointer wrap: C, then D and A competing.
    din[0] = 4'h9;
    din[2] = 4'hC;
    din[3] = 4'hD;
    apply(4'b0100, 1'b1);
    apply(4'b1001, 1'b1);
    apply(4'b1001, 1'b1);
    repeat (3) apply(4'b0000, 1'b1);

    // Reset while a word is stalled, then a lone request from C.
    din[1] = 4'h6;
    apply(4'b0010, 1'b0);
    apply(4'b0010, 1'b0);
    do_reset();
    din[2] = 4'h7;
    apply(4'b0100, 1'b1);
    repeat (2) apply(4'b0000, 1'b1);

    // Random traffic; data only changes while its request is low.
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (r[b]) begin
          if ($urandom_range(3) == 0) r[b] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          din[b] = N'($urandom);
          r[b]   = 1'b1;
        end
      end
      apply(r, $urandom_range(2) != 0);
    end
    repeat (4) apply(4'b0000, 1'b1);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
